// File: rtl/op_select_ctrl.sv
// Push-button operation selector: two-flop sync, per-button debounce, press/hold/auto-repeat FSM,
// and a wrapping registered operation index with one-hot indicator and change strobe.
module op_select_ctrl #(
  parameter int unsigned fpga_f      = 50_000_000,
  parameter int unsigned n_ops       = 4,
  parameter int unsigned debounce_ms = 20,
  parameter int unsigned hold_ms     = 500,
  parameter int unsigned rate_ms     = 200,
  localparam int unsigned W          = $clog2(n_ops)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             enable,
  output logic [W-1:0]     op_sel,
  output logic [n_ops-1:0] op_onehot,
  output logic             op_changed
);

  localparam int unsigned DEB_RAW  = fpga_f / 1000 * debounce_ms;
  localparam int unsigned HOLD_RAW = fpga_f / 1000 * hold_ms;
  localparam int unsigned RATE_RAW = fpga_f / 1000 * rate_ms;
  localparam int unsigned DEB_CYC  = (DEB_RAW  < 1) ? 1 : DEB_RAW;
  localparam int unsigned HOLD_CYC = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int unsigned RATE_CYC = (RATE_RAW < 1) ? 1 : RATE_RAW;
  localparam int unsigned TMR_MAX  = (HOLD_CYC > RATE_CYC) ? HOLD_CYC : RATE_CYC;
  localparam int unsigned DW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned TW       = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned N        = n_ops;

  // Bit 0 tracks btn_next, bit 1 tracks btn_prev throughout.
  localparam logic DIR_NEXT = 1'b0;
  localparam logic DIR_PREV = 1'b1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_e;

  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    clean_q, clean_d;
  logic [1:0]    clean_prev_q, clean_prev_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic [W-1:0]  op_sel_q, op_sel_d;
  logic [N-1:0]  op_onehot_q, op_onehot_d;
  logic          op_changed_q, op_changed_d;

  logic [1:0]    rise;
  logic          step;
  logic          step_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      clean_q      <= '0;
      clean_prev_q <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      state_q      <= IDLE;
      dir_q        <= DIR_NEXT;
      tmr_q        <= '0;
      op_sel_q     <= '0;
      op_onehot_q  <= N'(1);
      op_changed_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_prev_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      state_q      <= state_d;
      dir_q        <= dir_d;
      tmr_q        <= tmr_d;
      op_sel_q     <= op_sel_d;
      op_onehot_q  <= op_onehot_d;
      op_changed_q <= op_changed_d;
    end
  end

  // Synchroniser and debounce: clean follows synced after DEB_CYC stable cycles.
  always_comb begin
    sync1_d      = {btn_prev, btn_next};
    sync2_d      = sync1_q;
    clean_prev_d = clean_q;
    clean_d      = clean_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == clean_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DW'(DEB_CYC - 1)) begin
        clean_d[i]   = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  assign rise = clean_q & ~clean_prev_q;

  // Press / hold / repeat / lock sequencing; produces one step request per event.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tmr_d    = tmr_q;
    step     = 1'b0;
    step_dir = dir_q;
    case (state_q)
      IDLE: begin
        if (rise == 2'b11) begin
          state_d = LOCK;
        end else if (rise[0]) begin
          step     = 1'b1;
          step_dir = DIR_NEXT;
          dir_d    = DIR_NEXT;
          tmr_d    = TW'(HOLD_CYC - 1);
          state_d  = HOLD;
        end else if (rise[1]) begin
          step     = 1'b1;
          step_dir = DIR_PREV;
          dir_d    = DIR_PREV;
          tmr_d    = TW'(HOLD_CYC - 1);
          state_d  = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!clean_q[dir_q]) begin
          state_d = clean_q[~dir_q] ? LOCK : IDLE;
        end else if (tmr_q == '0) begin
          step    = 1'b1;
          tmr_d   = TW'(RATE_CYC - 1);
          state_d = REPEAT;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      LOCK: begin
        if (clean_q == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wrapping index update; enable gates the step but not the sequencing.
  always_comb begin
    op_sel_d     = op_sel_q;
    op_changed_d = 1'b0;
    if (step && enable) begin
      op_changed_d = 1'b1;
      if (step_dir == DIR_NEXT) begin
        op_sel_d = (op_sel_q == W'(N - 1)) ? '0 : op_sel_q + W'(1);
      end else begin
        op_sel_d = (op_sel_q == '0) ? W'(N - 1) : op_sel_q - W'(1);
      end
    end
    op_onehot_d = N'(1) << op_sel_d;
  end

  assign op_sel     = op_sel_q;
  assign op_onehot  = op_onehot_q;
  assign op_changed = op_changed_q;

endmodule

// File: tb/tb_op_select_ctrl.sv
// Directed bench for op_select_ctrl: table of single presses plus cycle-exact sequences
// for debounce latency, glitch rejection, auto-repeat, lock-out and reset mid-repeat.
module tb_op_select_ctrl;

  localparam int unsigned NO = 5;
  localparam int unsigned W  = 3;

  logic          clk;
  logic          reset;
  logic          btn_next;
  logic          btn_prev;
  logic          enable;
  logic [W-1:0]  op_sel;
  logic [NO-1:0] op_onehot;
  logic          op_changed;

  int n_cmp;
  int n_bad;
  int n_chg;

  op_select_ctrl #(
    .fpga_f      (1000),
    .n_ops       (NO),
    .debounce_ms (3),
    .hold_ms     (10),
    .rate_ms     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .enable     (enable),
    .op_sel     (op_sel),
    .op_onehot  (op_onehot),
    .op_changed (op_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_prev;
    logic          en;
    int            len;
    int            gap;
    logic [W-1:0]  exp_sel;
    logic [NO-1:0] exp_oh;
    int            exp_chg;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally strobes seen there.
  task automatic cyc();
    @(negedge clk);
    if (op_changed === 1'b1) n_chg++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_sel", 32'(op_sel), 0);
    check("reset_onehot", 32'(op_onehot), 1);
    check("reset_changed", 32'(op_changed), 0);
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] e;
    n_cmp    = 0;
    n_bad    = 0;
    n_chg    = 0;
    reset    = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    enable   = 1'b1;

    vecs[0] = '{1'b1, 1'b1, 6, 12, 3'd4, 5'b10000, 1};
    vecs[1] = '{1'b0, 1'b1, 6, 12, 3'd0, 5'b00001, 1};
    vecs[2] = '{1'b0, 1'b1, 6, 12, 3'd1, 5'b00010, 1};
    vecs[3] = '{1'b0, 1'b1, 6, 12, 3'd2, 5'b00100, 1};
    vecs[4] = '{1'b0, 1'b1, 6, 12, 3'd3, 5'b01000, 1};
    vecs[5] = '{1'b0, 1'b1, 6, 12, 3'd4, 5'b10000, 1};
    vecs[6] = '{1'b0, 1'b0, 6, 12, 3'd4, 5'b10000, 0};
    vecs[7] = '{1'b1, 1'b1, 6, 12, 3'd3, 5'b01000, 1};

    #2;
    do_reset();
    idle(2);

    // Single press: index moves exactly 6 cycles after the raw edge, no repeat.
    n_chg    = 0;
    btn_next = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check($sformatf("press_sel_c%0d", i), 32'(op_sel), (i >= 6) ? 1 : 0);
      check($sformatf("press_chg_c%0d", i), 32'(op_changed), (i == 6) ? 1 : 0);
    end
    btn_next = 1'b0;
    idle(14);
    check("press_count", 32'(n_chg), 1);
    check("press_sel", 32'(op_sel), 1);
    check("press_onehot", 32'(op_onehot), 32'b00010);

    // Two-cycle glitches never survive the debounce.
    do_reset();
    idle(2);
    n_chg = 0;
    for (int i = 0; i < 30; i++) begin
      btn_next = ((i % 4) < 2);
      cyc();
    end
    btn_next = 1'b0;
    idle(10);
    check("glitch_count", 32'(n_chg), 0);
    check("glitch_sel", 32'(op_sel), 0);

    // Table of short presses: wrap both ways, enable gating.
    for (int v = 0; v < 8; v++) begin
      n_chg  = 0;
      enable = vecs[v].en;
      if (vecs[v].is_prev) btn_prev = 1'b1;
      else                 btn_next = 1'b1;
      idle(vecs[v].len);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      idle(vecs[v].gap);
      enable = 1'b1;
      check($sformatf("vec%0d_sel", v), 32'(op_sel), 32'(vecs[v].exp_sel));
      check($sformatf("vec%0d_onehot", v), 32'(op_onehot), 32'(vecs[v].exp_oh));
      check($sformatf("vec%0d_count", v), 32'(n_chg), 32'(vecs[v].exp_chg));
    end

    // Hold next from 3: clean rise at cycle 5, steps at 6,16,20,24,28,32; prev pulse ignored.
    e = 3'd3;
    for (int i = 1; i <= 45; i++) begin
      logic stp;
      btn_next = (i <= 30);
      btn_prev = (i >= 10 && i <= 15);
      cyc();
      stp = (i == 6 || i == 16 || i == 20 || i == 24 || i == 28 || i == 32);
      if (stp) e = (e == 3'd4) ? 3'd0 : e + 3'd1;
      check($sformatf("hold_chg_c%0d", i), 32'(op_changed), 32'(stp));
      check($sformatf("hold_sel_c%0d", i), 32'(op_sel), 32'(e));
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    check("hold_onehot", 32'(op_onehot), 32'b10000);

    // Simultaneous press locks out; releasing one button keeps the lock.
    n_chg    = 0;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    idle(8);
    btn_next = 1'b0;
    idle(10);
    check("lock_partial_count", 32'(n_chg), 0);
    btn_prev = 1'b0;
    idle(10);
    check("lock_count", 32'(n_chg), 0);
    check("lock_sel", 32'(op_sel), 4);
    btn_prev = 1'b1;
    idle(6);
    btn_prev = 1'b0;
    idle(12);
    check("unlock_count", 32'(n_chg), 1);
    check("unlock_sel", 32'(op_sel), 3);

    // Reset mid-repeat with prev still held; a fresh press follows after release.
    btn_prev = 1'b1;
    idle(18);
    check("repeat_sel_before_reset", 32'(op_sel), 1);
    do_reset();
    n_chg = 0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      check($sformatf("rel_sel_c%0d", i), 32'(op_sel), (i >= 6) ? 4 : 0);
      check($sformatf("rel_chg_c%0d", i), 32'(op_changed), (i == 6) ? 1 : 0);
    end
    btn_prev = 1'b0;
    idle(14);
    check("rel_count", 32'(n_chg), 1);
    check("rel_onehot", 32'(op_onehot), 32'b10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/op_select_ctrl.md
Name: op_select_ctrl

Overview:
- Parametrised successor to the ALU operation-select logic.
- Turns two raw push-buttons (next/prev) into a registered operation index, with synchronisation, debounce, and press-and-hold auto-repeat.
- Selects among `n_ops` operations, wraps in both directions, and drives a one-hot indicator plus a change strobe.
- Sits between the board buttons and the ALU `ALUControl` / `curretOp` indicator in the top level; no longer clocks anything from a derived pulse.

Parameters:
- fpga_f, 50_000_000, clock frequency in Hz.
- n_ops, 4, number of selectable operations (>=2).
- debounce_ms, 20, time a raw level must be stable before it is accepted.
- hold_ms, 500, time a button is held before auto-repeat starts.
- rate_ms, 200, interval between auto-repeat steps.
- Derived: `W = $clog2(n_ops)`; `X_CYC = fpga_f/1000*X_ms` (minimum 1) for each time parameter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_next  in  1  raw, active-high, asynchronous to clk (already inverted at top).
- btn_prev  in  1  raw, active-high, asynchronous.
- enable  in  1  when 0, steps are suppressed.
- op_sel  out  W  current operation index.
- op_onehot  out  n_ops  `1 << op_sel`.
- op_changed  out  1  one-cycle strobe on every index update.

Behaviour:
- Reset: asynchronous, active-high. Values while reset is high:
  - op_sel=0, op_onehot=1, op_changed=0.
  - Synchroniser flops, clean levels and all counters = 0.
  - FSM = IDLE.
- Synchroniser: two flops per button.
- Debounce, per button:
  - Counter clears whenever the synced level equals the clean level.
  - Otherwise it increments.
  - When it reaches DEB_CYC-1 with the level still differing, clean <= synced and the counter clears.
  - Result: clean follows synced exactly DEB_CYC cycles after a stable change. Glitches shorter than that are ignored.
- Step: next -> op_sel+1, with n_ops-1 wrapping to 0. Prev -> op_sel-1, with 0 wrapping to n_ops-1.
- Step timing: op_sel, op_onehot and op_changed update in the cycle after the triggering FSM event.
- Step with enable=0: op_sel holds, op_changed stays 0, and the FSM still advances normally.
- Arithmetic: works for non-power-of-2 n_ops; op_sel never exceeds n_ops-1.
- FSM states: IDLE, HOLD, REPEAT, LOCK. A `dir` register records the active button.
  - IDLE, exactly one clean rising edge: step in that direction, load hold timer, set dir, go to HOLD.
  - IDLE, both clean edges in the same cycle: no step, go to LOCK.
  - HOLD: timer counts HOLD_CYC while the active button stays clean-high. At expiry: step, load rate timer, go to REPEAT.
  - REPEAT: a step every RATE_CYC cycles while the active button is held.
  - HOLD/REPEAT, active button clean-low: go to IDLE if the other button is clean-low, else go to LOCK.
  - HOLD/REPEAT: the other button is ignored; no direction change mid-hold.
  - LOCK: no steps; go to IDLE when both clean levels are 0.
- Reset mid-hold: everything returns to reset values at once. After reset releases, a still-pressed button must debounce again (clean=0 after reset) and then produces a new single press.
- op_changed: exactly one cycle high per step, and never high in two consecutive cycles unless RATE_CYC=1.

Test Plan:
All scenarios use fpga_f=1000, n_ops=5, debounce_ms=3, hold_ms=10, rate_ms=4, enable=1 unless stated.
1. Reset, then a 20-cycle press of btn_next -> op_sel 0->1 exactly 2+3+1 cycles after the raw edge; one op_changed; op_onehot=5'b00010; no repeat.
2. btn_next toggled with 2-cycle glitches for 30 cycles, then low -> op_sel stays 0; op_changed never asserted.
3. btn_prev from op_sel=0 with a short press -> op_sel=4, op_onehot=5'b10000. Five next presses from 4 -> sequence 0,1,2,3,4.
4. Hold btn_next for 30 cycles after clean rise -> steps at clean+1, clean+11, clean+15, clean+19, clean+23, clean+27; btn_prev pulsed mid-hold -> ignored.
5. Both buttons rising in the same cycle -> no step. Release next while prev is held -> still LOCK, no step. Release both, then press prev -> single decrement.
6. enable=0 during a press -> no change. Async reset asserted mid-REPEAT -> op_sel=0 immediately. Button kept held through reset release -> one new step after the debounce delay.
